// File: rtl/emulib_rammodel_pkg.sv
// Shared sizing helpers for the fixed-latency RAM timing model.
// The optional statistics block is enabled with EMULIB_RAMMODEL_STATS_EN.
package emulib_rammodel_pkg;

    // Width of a delay countdown able to hold the larger of the two latencies.
    function automatic int calc_cnt_width(input int r_delay, input int w_delay);
        int max_delay;
        max_delay = (r_delay > w_delay) ? r_delay : w_delay;
        return (max_delay < 1) ? 1 : $clog2(max_delay + 1);
    endfunction

    function automatic int calc_ptr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/emulib_rammodel_delay_queue.sv
// In-order FIFO where every entry carries its own saturating countdown;
// head_due flags that the oldest entry has finished its delay.
module emulib_rammodel_delay_queue
    import emulib_rammodel_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int DELAY      = 1,
    parameter int CNT_WIDTH  = calc_cnt_width(DELAY, DELAY)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  head_due,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int PTR_WIDTH = calc_ptr_width(DEPTH);
    localparam logic [CNT_WIDTH-1:0] START_CNT = CNT_WIDTH'(DELAY - 1);

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [CNT_WIDTH-1:0]  cnt_mem  [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH:0]    count;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;

    assign full      = (count == (PTR_WIDTH + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = data_mem[rd_ptr];
    assign head_due  = !empty && (cnt_mem[rd_ptr] == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A pushed entry starts at DELAY-1 because it only becomes visible the
    // cycle after the handshake, so it is due exactly DELAY cycles later.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                cnt_mem[i] <= '0;
            end else if (do_push && (wr_ptr == PTR_WIDTH'(i))) begin
                cnt_mem[i] <= START_CNT;
            end else if (cnt_mem[i] != '0) begin
                cnt_mem[i] <= cnt_mem[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) data_mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/emulib_rammodel_fixed_timing.sv
// Fixed-latency timing model: delays accepted reads/writes into rreq/breq events.
// Define EMULIB_RAMMODEL_STATS_EN to add burst and stall statistics outputs.
module emulib_rammodel_fixed_timing
    import emulib_rammodel_pkg::*;
#(
    parameter int ID_WIDTH     = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int R_DELAY      = 25,
    parameter int W_DELAY      = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                areq_valid,
    output logic                areq_ready,
    input  logic                areq_write,
    input  logic [ID_WIDTH-1:0] areq_id,
    input  logic [7:0]          areq_len,
    input  logic                wreq_valid,
    output logic                wreq_ready,
    input  logic                wreq_last,
    output logic                breq_valid,
    input  logic                breq_ready,
    output logic [ID_WIDTH-1:0] breq_id,
    output logic                rreq_valid,
    input  logic                rreq_ready,
    output logic [ID_WIDTH-1:0] rreq_id,
    output logic                rreq_last
`ifdef EMULIB_RAMMODEL_STATS_EN
    ,
    output logic [31:0]         stat_rd_bursts,
    output logic [31:0]         stat_wr_bursts,
    output logic [31:0]         stat_stall_cycles
`endif
);

    localparam int CNT_WIDTH = calc_cnt_width(R_DELAY, W_DELAY);
    localparam int PTR_WIDTH = calc_ptr_width(MAX_INFLIGHT);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [7:0]          len;
    } rd_payload_t;

    rd_payload_t         rd_push;
    rd_payload_t         rd_head;
    logic                rq_full;
    logic                rq_due;
    logic                rd_accept;
    logic                rd_pop;
    logic [7:0]          beat;

    logic [ID_WIDTH-1:0] aw_mem [MAX_INFLIGHT];
    logic [PTR_WIDTH-1:0] aw_wr_ptr;
    logic [PTR_WIDTH-1:0] aw_rd_ptr;
    logic [PTR_WIDTH:0]  aw_count;
    logic                aw_full;
    logic                aw_empty;
    logic                wr_accept;
    logic                wlast_hs;
    logic                wr_complete;
    logic [PTR_WIDTH:0]  wdone;
    logic [ID_WIDTH-1:0] wq_push_id;
    logic [ID_WIDTH-1:0] wq_head;
    logic                wq_full;
    logic                wq_due;

    assign areq_ready = areq_write ? !aw_full : !rq_full;
    assign rd_accept  = areq_valid && areq_ready && !areq_write;
    assign wr_accept  = areq_valid && areq_ready && areq_write;
    assign rd_push    = '{id: areq_id, len: areq_len};

    emulib_rammodel_delay_queue #(
        .DATA_WIDTH ($bits(rd_payload_t)),
        .DEPTH      (MAX_INFLIGHT),
        .DELAY      (R_DELAY),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_read_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_accept),
        .push_data (rd_push),
        .pop       (rd_pop),
        .full      (rq_full),
        .head_due  (rq_due),
        .head_data (rd_head)
    );

    assign rreq_valid = rq_due;
    assign rreq_id    = rq_due ? rd_head.id : '0;
    assign rreq_last  = rq_due && (beat == rd_head.len);
    assign rd_pop     = rreq_valid && rreq_ready && rreq_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
        end else if (rreq_valid && rreq_ready) begin
            beat <= rreq_last ? 8'd0 : beat + 8'd1;
        end
    end

    assign aw_full    = (aw_count == (PTR_WIDTH + 1)'(MAX_INFLIGHT));
    assign aw_empty   = (aw_count == '0);
    assign wlast_hs   = wreq_valid && wreq_ready && wreq_last;
    assign wreq_ready = (wdone < (PTR_WIDTH + 1)'(MAX_INFLIGHT));

    // Either half of a write may arrive in the completing cycle itself, so an
    // AW accepted this cycle bypasses the pending FIFO when it is empty.
    assign wr_complete = (!aw_empty || wr_accept) && ((wdone != '0) || wlast_hs) && !wq_full;
    assign wq_push_id  = aw_empty ? areq_id : aw_mem[aw_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_wr_ptr <= '0;
            aw_rd_ptr <= '0;
            aw_count  <= '0;
            wdone     <= '0;
        end else begin
            if (wr_accept)   aw_wr_ptr <= aw_wr_ptr + 1'b1;
            if (wr_complete) aw_rd_ptr <= aw_rd_ptr + 1'b1;
            case ({wr_accept, wr_complete})
                2'b10:   aw_count <= aw_count + 1'b1;
                2'b01:   aw_count <= aw_count - 1'b1;
                default: aw_count <= aw_count;
            endcase
            case ({wlast_hs, wr_complete})
                2'b10:   wdone <= wdone + 1'b1;
                2'b01:   wdone <= wdone - 1'b1;
                default: wdone <= wdone;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) aw_mem[aw_wr_ptr] <= areq_id;
    end

    emulib_rammodel_delay_queue #(
        .DATA_WIDTH (ID_WIDTH),
        .DEPTH      (MAX_INFLIGHT),
        .DELAY      (W_DELAY),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_write_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_complete),
        .push_data (wq_push_id),
        .pop       (breq_valid && breq_ready),
        .full      (wq_full),
        .head_due  (wq_due),
        .head_data (wq_head)
    );

    assign breq_valid = wq_due;
    assign breq_id    = wq_due ? wq_head : '0;

`ifdef EMULIB_RAMMODEL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_bursts    <= '0;
            stat_wr_bursts    <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (rd_accept)                 stat_rd_bursts    <= stat_rd_bursts + 32'd1;
            if (wr_accept)                 stat_wr_bursts    <= stat_wr_bursts + 32'd1;
            if (areq_valid && !areq_ready) stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_emulib_rammodel_fixed_timing.sv
// Bench for emulib_rammodel_fixed_timing: queue-based timing model plus directed latency pins.
// Also checks the statistics outputs when EMULIB_RAMMODEL_STATS_EN is defined.
module tb_emulib_rammodel_fixed_timing;

    localparam int ID_WIDTH     = 4;
    localparam int MAX_INFLIGHT = 8;
    localparam int R_DELAY      = 25;
    localparam int W_DELAY      = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                areq_valid = 1'b0;
    logic                areq_ready;
    logic                areq_write = 1'b0;
    logic [ID_WIDTH-1:0] areq_id = '0;
    logic [7:0]          areq_len = '0;
    logic                wreq_valid = 1'b0;
    logic                wreq_ready;
    logic                wreq_last = 1'b0;
    logic                breq_valid;
    logic                breq_ready = 1'b0;
    logic [ID_WIDTH-1:0] breq_id;
    logic                rreq_valid;
    logic                rreq_ready = 1'b0;
    logic [ID_WIDTH-1:0] rreq_id;
    logic                rreq_last;
`ifdef EMULIB_RAMMODEL_STATS_EN
    logic [31:0]         stat_rd_bursts;
    logic [31:0]         stat_wr_bursts;
    logic [31:0]         stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    emulib_rammodel_fixed_timing #(
        .ID_WIDTH     (ID_WIDTH),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .R_DELAY      (R_DELAY),
        .W_DELAY      (W_DELAY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .areq_valid (areq_valid),
        .areq_ready (areq_ready),
        .areq_write (areq_write),
        .areq_id    (areq_id),
        .areq_len   (areq_len),
        .wreq_valid (wreq_valid),
        .wreq_ready (wreq_ready),
        .wreq_last  (wreq_last),
        .breq_valid (breq_valid),
        .breq_ready (breq_ready),
        .breq_id    (breq_id),
        .rreq_valid (rreq_valid),
        .rreq_ready (rreq_ready),
        .rreq_id    (rreq_id),
        .rreq_last  (rreq_last)
`ifdef EMULIB_RAMMODEL_STATS_EN
        ,
        .stat_rd_bursts    (stat_rd_bursts),
        .stat_wr_bursts    (stat_wr_bursts),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return shortly before the rising edge.
    task automatic applyStimulus(input bit r, input bit av, input bit aw, input int aid, input int alen,
                                 input bit wv, input bit wl, input bit br, input bit rr);
        @(negedge clk);
        rst        = r;
        areq_valid = av;
        areq_write = aw;
        areq_id    = ID_WIDTH'(aid);
        areq_len   = 8'(alen);
        wreq_valid = wv;
        wreq_last  = wl;
        breq_ready = br;
        rreq_ready = rr;
        #3;
    endtask

    task automatic idleCycles(input int n, input bit br, input bit rr);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, br, rr);
    endtask

    // Behavioural model: absolute due cycles per burst, plain queues per direction.
    typedef struct {
        int     id;
        int     len;
        longint due;
    } rd_ent_t;

    typedef struct {
        int     id;
        longint due;
    } wr_ent_t;

    rd_ent_t m_rq[$];
    wr_ent_t m_wq[$];
    int      m_aw[$];
    int      m_wdone = 0;
    int      m_beat  = 0;
    longint  cyc     = 0;
    int      m_rd_cnt = 0;
    int      m_wr_cnt = 0;
    int      m_stall  = 0;

    initial begin : compare_proc
        bit e_aready, e_wready, e_rvalid, e_bvalid, e_rlast;
        bit a_acc, wr_acc, rd_acc, wl, comp;
        int cid;
        forever begin
            @(negedge clk);
            #2;
            e_aready = areq_write ? (m_aw.size() < MAX_INFLIGHT) : (m_rq.size() < MAX_INFLIGHT);
            e_wready = (m_wdone < MAX_INFLIGHT);
            e_rvalid = 1'b0;
            e_rlast  = 1'b0;
            if (m_rq.size() > 0) begin
                e_rvalid = (cyc >= m_rq[0].due);
                e_rlast  = (m_beat == m_rq[0].len);
            end
            e_bvalid = 1'b0;
            if (m_wq.size() > 0) e_bvalid = (cyc >= m_wq[0].due);

            if (chk_en) begin
                checkOutput("areq_ready", 32'(areq_ready), 32'(e_aready));
                checkOutput("wreq_ready", 32'(wreq_ready), 32'(e_wready));
                checkOutput("rreq_valid", 32'(rreq_valid), 32'(e_rvalid));
                checkOutput("breq_valid", 32'(breq_valid), 32'(e_bvalid));
                if (e_rvalid) begin
                    checkOutput("rreq_id", 32'(rreq_id), 32'(m_rq[0].id));
                    checkOutput("rreq_last", 32'(rreq_last), 32'(e_rlast));
                end
                if (e_bvalid) checkOutput("breq_id", 32'(breq_id), 32'(m_wq[0].id));
`ifdef EMULIB_RAMMODEL_STATS_EN
                checkOutput("stat_rd_bursts", stat_rd_bursts, 32'(m_rd_cnt));
                checkOutput("stat_wr_bursts", stat_wr_bursts, 32'(m_wr_cnt));
                checkOutput("stat_stall_cycles", stat_stall_cycles, 32'(m_stall));
`endif
            end

            if (rst) begin
                m_rq.delete();
                m_wq.delete();
                m_aw.delete();
                m_wdone  = 0;
                m_beat   = 0;
                m_rd_cnt = 0;
                m_wr_cnt = 0;
                m_stall  = 0;
            end else begin
                a_acc  = areq_valid && e_aready;
                wr_acc = a_acc && areq_write;
                rd_acc = a_acc && !areq_write;
                wl     = wreq_valid && e_wready && wreq_last;
                comp   = ((m_aw.size() > 0) || wr_acc) && ((m_wdone > 0) || wl) && (m_wq.size() < MAX_INFLIGHT);
                cid    = int'(areq_id);
                if (m_aw.size() > 0) cid = m_aw[0];

                if (e_rvalid && rreq_ready) begin
                    if (e_rlast) begin
                        void'(m_rq.pop_front());
                        m_beat = 0;
                    end else begin
                        m_beat++;
                    end
                end
                if (e_bvalid && breq_ready) void'(m_wq.pop_front());
                if (rd_acc) m_rq.push_back('{id: int'(areq_id), len: int'(areq_len), due: cyc + R_DELAY});
                if (wr_acc) m_aw.push_back(int'(areq_id));
                if (comp) begin
                    void'(m_aw.pop_front());
                    m_wq.push_back('{id: cid, due: cyc + W_DELAY});
                end
                m_wdone = m_wdone + (wl ? 1 : 0) - (comp ? 1 : 0);
                if (rd_acc) m_rd_cnt++;
                if (wr_acc) m_wr_cnt++;
                if (areq_valid && !e_aready) m_stall++;
            end
            cyc++;
        end
    end

    initial begin : stimulus_proc
        int found, beats, acc, seen;
        bit a_pend, w_pend;
        bit s_av, s_aw, s_wv, s_wl, s_r;
        int s_aid, s_alen, ph;
        int p_av[4], p_aw[4], p_wv[4], p_wl[4], p_rr[4], p_br[4];

        // Reset and idle outputs
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_areq_ready_rd", 32'(areq_ready), 32'd1);
        checkOutput("reset_wreq_ready", 32'(wreq_ready), 32'd1);
        checkOutput("reset_breq_valid", 32'(breq_valid), 32'd0);
        checkOutput("reset_rreq_valid", 32'(rreq_valid), 32'd0);
        checkOutput("reset_breq_id", 32'(breq_id), 32'd0);
        checkOutput("reset_rreq_id", 32'(rreq_id), 32'd0);
        checkOutput("reset_rreq_last", 32'(rreq_last), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_areq_ready_wr", 32'(areq_ready), 32'd1);

        // Single read id=3 len=0: first beat exactly R_DELAY cycles after accept
        applyStimulus(1'b0, 1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rd1_accept", 32'(areq_ready), 32'd1);
        found = 0;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (rreq_valid) begin
                found = k;
                checkOutput("rd1_id", 32'(rreq_id), 32'd3);
                checkOutput("rd1_last", 32'(rreq_last), 32'd1);
                break;
            end
        end
        checkOutput("rd1_latency", 32'(found), 32'd25);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rd1_one_beat", 32'(rreq_valid), 32'd0);

        // Read id=9 len=3 with rreq_ready toggling
        applyStimulus(1'b0, 1'b1, 1'b0, 9, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        beats = 0;
        for (int k = 0; k < 80 && beats < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'(k % 2));
            if (rreq_valid) begin
                checkOutput("rd4_id", 32'(rreq_id), 32'd9);
                if (rreq_ready) begin
                    beats++;
                    checkOutput("rd4_last", 32'(rreq_last), 32'(beats == 4));
                end else begin
                    checkOutput("rd4_last_stalled", 32'(rreq_last), 32'(beats == 3));
                end
            end
        end
        checkOutput("rd4_beats", 32'(beats), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rd4_done", 32'(rreq_valid), 32'd0);

        // W-last first, AW id=5 ten cycles later, then the reverse order with id=6
        for (int order = 0; order < 2; order++) begin
            if (order == 0) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
            else            applyStimulus(1'b0, 1'b1, 1'b1, 6, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            idleCycles(9, 1'b1, 1'b1);
            if (order == 0) applyStimulus(1'b0, 1'b1, 1'b1, 5, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            else            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
            found = 0;
            for (int k = 1; k <= 20; k++) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
                if (breq_valid) begin
                    found = k;
                    checkOutput("wr_breq_id", 32'(breq_id), (order == 0) ? 32'd5 : 32'd6);
                    break;
                end
            end
            checkOutput("wr_latency", 32'(found), 32'd3);
            idleCycles(2, 1'b1, 1'b1);
        end

        // Nine back-to-back reads without draining: only eight fit
        acc = 0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, i, 0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (areq_ready) acc++;
            if (i == 8) checkOutput("fill_9th_ready", 32'(areq_ready), 32'd0);
        end
        checkOutput("fill_accepted", 32'(acc), 32'd8);
        applyStimulus(1'b0, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("fill_write_ready", 32'(areq_ready), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
        idleCycles(60, 1'b1, 1'b1);

        // Reset with two reads in flight drops them
        applyStimulus(1'b0, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 2, 1, 1'b0, 1'b0, 1'b1, 1'b1);
        idleCycles(10, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_areq_ready", 32'(areq_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
            if (rreq_valid) seen++;
        end
        checkOutput("rst_no_rreq", 32'(seen), 32'd0);

        // Randomized traffic in phases that stress each full condition
        p_av = '{50, 80, 70, 10};
        p_aw = '{50, 10, 90, 50};
        p_wv = '{50, 30, 20, 90};
        p_wl = '{50, 50, 30, 90};
        p_rr = '{80, 10, 70, 60};
        p_br = '{30, 70, 20, 60};
        a_pend = 1'b0;
        w_pend = 1'b0;
        s_av = 1'b0; s_aw = 1'b0; s_aid = 0; s_alen = 0; s_wv = 1'b0; s_wl = 1'b0;
        for (int i = 0; i < 3200; i++) begin
            ph = (i / 400) % 4;
            s_r = ($urandom_range(0, 999) == 0);
            if (!a_pend) begin
                s_av   = ($urandom_range(0, 99) < p_av[ph]);
                s_aw   = ($urandom_range(0, 99) < p_aw[ph]);
                s_aid  = int'($urandom_range(0, 15));
                s_alen = int'($urandom_range(0, 5));
            end
            if (!w_pend) begin
                s_wv = ($urandom_range(0, 99) < p_wv[ph]);
                s_wl = ($urandom_range(0, 99) < p_wl[ph]);
            end
            applyStimulus(s_r, s_av, s_aw, s_aid, s_alen, s_wv, s_wl,
                          ($urandom_range(0, 99) < p_br[ph]), ($urandom_range(0, 99) < p_rr[ph]));
            a_pend = s_av && !areq_ready && !s_r;
            w_pend = s_wv && !wreq_ready && !s_r;
        end
        idleCycles(150, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
